// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: front-end hold/flush sequencer for load-use, multi-cycle and mispredict hazards.
// 0-cycle input->control latency; PIPE_HAZARD_PERF_EN builds saturating stall/flush perf counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT      = 4,
  parameter int REDIRECT_LAT = 1,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_mispredict,
  input  logic             mc_start,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idiss_flush,
  output logic [1:0]       state,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_cycles
);

  localparam int MAX_LAT = (MUL_LAT > REDIRECT_LAT) ? MUL_LAT : REDIRECT_LAT;
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MCSTALL = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;

  assign lu = ex_memread && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idiss_flush = 1'b0;
    case (state_q)
      S_RUN, S_MCSTALL: begin
        if (ex_mispredict) begin
          // A resolved mispredict kills everything younger, including a pending stall.
          ifid_flush  = 1'b1;
          idiss_flush = 1'b1;
          if (REDIRECT_LAT > 0) begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(REDIRECT_LAT);
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_MCSTALL) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idiss_flush = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (mc_start) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idiss_flush = 1'b1;
          if (MUL_LAT > 1) begin
            state_d = S_MCSTALL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end else if (lu) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idiss_flush = 1'b1;
        end
      end
      S_FLUSH: begin
        // ID holds a wrong-path bubble here, so mc_start and lu carry no meaning.
        ifid_flush  = 1'b1;
        idiss_flush = 1'b1;
        if (ex_mispredict) begin
          cnt_d = CNT_W'(REDIRECT_LAT);
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (ifid_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and recovery sequencer that drives the hold and flush controls of the fetch/decode and decode/issue pipeline registers, plus the PC hold. It sits beside the front end. It watches ID-stage operands, the EX-stage load and branch outcome, and multi-cycle op issue. From these it decides, cycle by cycle, whether the front end advances, stalls, or discards wrong-path instructions.

## Interface
- MUL_LAT, 4, total front-end stall cycles per multi-cycle op (>=1)
- REDIRECT_LAT, 1, extra flush cycles after a mispredict while the wrong-path fetch drains (>=0)
- REG_W, 5, register index width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_rs  in  REG_W  ID-stage source register 1
- id_rt  in  REG_W  ID-stage source register 2
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_rd  in  REG_W  EX-stage destination register
- ex_memread  in  1  EX instruction is a load
- ex_mispredict  in  1  EX branch resolved opposite to prediction (single-cycle pulse)
- mc_start  in  1  ID instruction is a multi-cycle op being issued this cycle
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze fetch/decode register
- ifid_flush  out  1  clear fetch/decode register
- idiss_flush  out  1  clear decode/issue register (inject bubble)
- state  out  2  0=RUN, 1=MCSTALL, 2=FLUSH
- stall_cycles  out  16  perf count of stalled cycles (see Configuration)
- flush_cycles  out  16  perf count of flush cycles (see Configuration)

## Operation
- Outputs are combinational from the current state and the current inputs.
- Registered state: `state`, the down-counter `cnt` (width clog2(max(MUL_LAT,REDIRECT_LAT)+1)), and the perf counters.
- Load-use hazard `lu` = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Priority in every state: ex_mispredict > mc_start > lu.

RUN:
- ex_mispredict: ifid_flush=1 and idiss_flush=1 this cycle.
  - If REDIRECT_LAT>0: next=FLUSH, cnt<=REDIRECT_LAT.
  - Otherwise stay in RUN.
- mc_start: pc_hold=ifid_hold=idiss_flush=1.
  - If MUL_LAT>1: next=MCSTALL, cnt<=MUL_LAT-1.
  - Otherwise stay in RUN.
- lu: pc_hold=ifid_hold=idiss_flush=1 for exactly this cycle; no state change.
- None of the above: all control outputs 0.

MCSTALL:
- pc_hold=ifid_hold=idiss_flush=1 every cycle.
- cnt==1: next=RUN. Otherwise cnt<=cnt-1.
- ex_mispredict overrides: behaves exactly as the RUN mispredict case, aborting the stall.

FLUSH:
- ifid_flush=idiss_flush=1; pc_hold=ifid_hold=0.
- mc_start and lu are ignored, because ID holds a bubble.
- cnt==1: next=RUN. Otherwise cnt<=cnt-1.
- ex_mispredict reloads cnt<=REDIRECT_LAT and stays in FLUSH.

Boundary rules:
- ifid_flush and ifid_hold are never both 1.
- Flush wins over hold.
- Illegal state encoding 3 returns to RUN next cycle, with all control outputs 0.

## Timing
- Reset values: state=RUN, cnt=0, all control outputs 0 (while no hazard inputs are asserted), stall_cycles=flush_cycles=0.
- Reset asserted mid-MCSTALL or mid-FLUSH aborts immediately. The first cycle after release is RUN.
- Latency from input to control output is 0 cycles (same cycle).
- A multi-cycle op stalls the front end for exactly MUL_LAT cycles, counting the mc_start cycle.
- A mispredict flushes for exactly 1+REDIRECT_LAT cycles.
- A load-use stall lasts exactly 1 cycle.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with pc_hold=1.
  - flush_cycles increments on every cycle with ifid_flush=1.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- PIPE_HAZARD_PERF_EN undefined: the counters are not built, and both ports are driven constant 0.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs=5 for one cycle -> pc_hold/ifid_hold/idiss_flush=1 for that cycle only; state stays 0. Repeat with ex_rd=0 -> no stall.
- Multi-cycle, MUL_LAT=4: mc_start pulse at cycle t -> pc_hold=1 in cycles t..t+3, state=1 in t+1..t+3, state=0 at t+4.
- Mispredict, REDIRECT_LAT=1: pulse at cycle t -> ifid_flush=idiss_flush=1 in t and t+1, state=0 at t+2.
- Simultaneous events:
  - ex_mispredict, mc_start and lu together -> flush only, no hold.
  - Mispredict at the second cycle of MCSTALL -> immediate flush, stall aborted.
  - Second mispredict in FLUSH -> flush extended by REDIRECT_LAT more cycles.
- Reset in the middle of MCSTALL (cnt=2) -> outputs 0 and state=0 immediately; normal operation on the first cycle after release.
- With PIPE_HAZARD_PERF_EN: run the MUL_LAT=4 case then the mispredict case -> stall_cycles=4, flush_cycles=2. Without the macro -> both read 0.
